// File: rtl/sign_extend_unit_if.sv
`default_nettype none
// ------------------------------------------------------------------
// sign_extend_unit_if : field/result bundle for sign_extend_unit
// Revision 1.0
// ------------------------------------------------------------------
interface sign_extend_unit_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
);
  logic [IN_W-1:0]  in;
  logic             zero_ext;
  logic             in_valid;
  logic [OUT_W-1:0] out;
  logic             is_neg;
  logic [OUT_W-1:0] out_q;
  logic             out_valid;

  modport master (
    output in, zero_ext, in_valid,
    input  out, is_neg, out_q, out_valid
  );

  modport slave (
    input  in, zero_ext, in_valid,
    output out, is_neg, out_q, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/sign_extend_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// sign_extend_unit : IN_W -> OUT_W sign/zero extension, comb + registered
// Revision 1.0
// ------------------------------------------------------------------
module sign_extend_unit #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  sign_extend_unit_if.slave bus
);
  logic             w_fill;
  logic [OUT_W-1:0] w_ext;
  logic [OUT_W-1:0] r_out_q;
  logic             r_out_valid;

  // Fill bit doubles as the negative flag: only a sign-extended MSB of 1 is negative.
  assign w_fill = bus.in[IN_W-1] & ~bus.zero_ext;

  generate
    if (OUT_W == IN_W) begin : g_pass
      assign w_ext = bus.in;
    end else begin : g_ext
      assign w_ext = {{(OUT_W-IN_W){w_fill}}, bus.in};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_q     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_out_q <= w_ext;
      end
    end
  end

  assign bus.out       = w_ext;
  assign bus.is_neg    = w_fill;
  assign bus.out_q     = r_out_q;
  assign bus.out_valid = r_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_sign_extend_unit.sv
`default_nettype none
// Randomized and directed checks of sign_extend_unit in 4->8, 4->4 and 8->16 configurations
// against an arithmetic reference model.
module tb_sign_extend_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sign_extend_unit_if #(.IN_W(4), .OUT_W(8))  b4 ();
  sign_extend_unit_if #(.IN_W(4), .OUT_W(4))  bp ();
  sign_extend_unit_if #(.IN_W(8), .OUT_W(16)) bw ();

  sign_extend_unit #(.IN_W(4), .OUT_W(8))  dut4 (.clk(clk), .rst(rst), .bus(b4));
  sign_extend_unit #(.IN_W(4), .OUT_W(4))  dutp (.clk(clk), .rst(rst), .bus(bp));
  sign_extend_unit #(.IN_W(8), .OUT_W(16)) dutw (.clk(clk), .rst(rst), .bus(bw));

  // Expected registered state, advanced by tick()
  logic [7:0]  e4_q;
  logic        e4_v;
  logic [3:0]  ep_q;
  logic        ep_v;
  logic [15:0] ew_q;
  logic        ew_v;

  // Reference: interpret the field as a signed (or unsigned) number, then re-encode it.
  function automatic logic [7:0] ref4(input logic [3:0] v, input logic zx);
    int n;
    logic [31:0] t;
    n = int'(v);
    if (!zx && n >= 8) n = n - 16;
    t = n;
    return t[7:0];
  endfunction

  function automatic logic [15:0] ref16(input logic [7:0] v, input logic zx);
    int n;
    logic [31:0] t;
    n = int'(v);
    if (!zx && n >= 128) n = n - 256;
    t = n;
    return t[15:0];
  endfunction

  function automatic logic refneg(input int v, input int msb_weight, input logic zx);
    return (!zx && v >= msb_weight);
  endfunction

  task automatic set4(input logic [3:0] v, input logic zx, input logic vld);
    b4.in = v; b4.zero_ext = zx; b4.in_valid = vld;
    bp.in = v; bp.zero_ext = zx; bp.in_valid = vld;
  endtask

  task automatic setw(input logic [7:0] v, input logic zx, input logic vld);
    bw.in = v; bw.zero_ext = zx; bw.in_valid = vld;
  endtask

  task automatic tick();
    if (rst) begin
      e4_q = '0; e4_v = 1'b0;
      ep_q = '0; ep_v = 1'b0;
      ew_q = '0; ew_v = 1'b0;
    end else begin
      e4_v = b4.in_valid;
      if (b4.in_valid) e4_q = ref4(b4.in, b4.zero_ext);
      ep_v = bp.in_valid;
      if (bp.in_valid) ep_q = bp.in;
      ew_v = bw.in_valid;
      if (bw.in_valid) ew_q = ref16(bw.in, bw.zero_ext);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set4(4'(4 + 7*i), 1'b0, 1'b1);
      setw(8'h80, 1'b0, 1'b1);
      tick();
      checks++;
      if (b4.out_q !== 8'h00 || b4.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_regs cyc=%0d got q=%h v=%b exp q=00 v=0", i, b4.out_q, b4.out_valid);
      end
      checks++;
      if (bw.out_q !== 16'h0000 || bw.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_regs_w cyc=%0d got q=%h v=%b exp q=0000 v=0", i, bw.out_q, bw.out_valid);
      end
      set4(4'(9 + i), 1'b0, 1'b1);
      #1;
      checks++;
      if (b4.out !== ref4(4'(9 + i), 1'b0)) begin
        errors++;
        $display("FAIL reset_comb in=%h got=%h exp=%h", b4.in, b4.out, ref4(4'(9 + i), 1'b0));
      end
    end
    set4(4'h0, 1'b0, 1'b0);
    setw(8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sweep(input logic zx);
    for (int v = 0; v < 16; v++) begin
      set4(4'(v), zx, 1'b0);
      #1;
      checks++;
      if (b4.out !== ref4(4'(v), zx) || b4.is_neg !== refneg(v, 8, zx)) begin
        errors++;
        $display("FAIL sweep zx=%b in=%h got out=%h neg=%b exp out=%h neg=%b",
                 zx, v[3:0], b4.out, b4.is_neg, ref4(4'(v), zx), refneg(v, 8, zx));
      end
      checks++;
      if (bp.out !== 4'(v) || bp.is_neg !== refneg(v, 8, zx)) begin
        errors++;
        $display("FAIL sweep_pass zx=%b in=%h got out=%h neg=%b exp out=%h",
                 zx, v[3:0], bp.out, bp.is_neg, v[3:0]);
      end
      tick();
      checks++;
      if (b4.out_q !== e4_q || b4.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL sweep_hold got q=%h v=%b exp q=%h v=0", b4.out_q, b4.out_valid, e4_q);
      end
    end
  endtask

  task automatic test_back_to_back();
    set4(4'hA, 1'b0, 1'b1);
    tick();
    checks++;
    if (b4.out_q !== 8'hFA || b4.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_beat1 got q=%h v=%b exp q=fa v=1", b4.out_q, b4.out_valid);
    end
    set4(4'h3, 1'b0, 1'b1);
    tick();
    checks++;
    if (b4.out_q !== 8'h03 || b4.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_beat2 got q=%h v=%b exp q=03 v=1", b4.out_q, b4.out_valid);
    end
    set4(4'hC, 1'b0, 1'b0);
    tick();
    checks++;
    if (b4.out_q !== 8'h03 || b4.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got q=%h v=%b exp q=03 v=0", b4.out_q, b4.out_valid);
    end
  endtask

  task automatic test_reset_priority();
    set4(4'h9, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    checks++;
    if (b4.out_q !== 8'h00 || b4.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_prio got q=%h v=%b exp q=00 v=0", b4.out_q, b4.out_valid);
    end
    rst = 1'b0;
    set4(4'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_wide();
    logic [7:0]  vals [3] = '{8'h80, 8'h7F, 8'h80};
    logic        zxs  [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] exps [3] = '{16'hFF80, 16'h007F, 16'h0080};
    for (int i = 0; i < 3; i++) begin
      setw(vals[i], zxs[i], 1'b1);
      #1;
      checks++;
      if (bw.out !== exps[i]) begin
        errors++;
        $display("FAIL wide in=%h zx=%b got=%h exp=%h", vals[i], zxs[i], bw.out, exps[i]);
      end
      tick();
      checks++;
      if (bw.out_q !== exps[i] || bw.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL wide_q in=%h got q=%h v=%b exp q=%h v=1", vals[i], bw.out_q, bw.out_valid, exps[i]);
      end
    end
    setw(8'h00, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 19) == 0);
      set4(4'($urandom), 1'($urandom), 1'($urandom));
      setw(8'($urandom), 1'($urandom), 1'($urandom));
      #1;
      checks++;
      if (b4.out !== ref4(b4.in, b4.zero_ext) || bw.out !== ref16(bw.in, bw.zero_ext) ||
          bp.out !== bp.in) begin
        errors++;
        $display("FAIL rand_comb c=%0d out4=%h exp=%h outw=%h exp=%h outp=%h exp=%h", c,
                 b4.out, ref4(b4.in, b4.zero_ext), bw.out, ref16(bw.in, bw.zero_ext), bp.out, bp.in);
      end
      checks++;
      if (b4.is_neg !== refneg(int'(b4.in), 8, b4.zero_ext) ||
          bw.is_neg !== refneg(int'(bw.in), 128, bw.zero_ext)) begin
        errors++;
        $display("FAIL rand_neg c=%0d neg4=%b negw=%b", c, b4.is_neg, bw.is_neg);
      end
      tick();
      checks++;
      if (b4.out_q !== e4_q || b4.out_valid !== e4_v || bp.out_q !== ep_q || bp.out_valid !== ep_v ||
          bw.out_q !== ew_q || bw.out_valid !== ew_v) begin
        errors++;
        $display("FAIL rand_reg c=%0d q4=%h/%b exp %h/%b qp=%h/%b exp %h/%b qw=%h/%b exp %h/%b", c,
                 b4.out_q, b4.out_valid, e4_q, e4_v, bp.out_q, bp.out_valid, ep_q, ep_v,
                 bw.out_q, bw.out_valid, ew_q, ew_v);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    set4(4'h0, 1'b0, 1'b0);
    setw(8'h00, 1'b0, 1'b0);
    test_reset();
    test_sweep(1'b0);
    test_sweep(1'b1);
    test_back_to_back();
    test_reset_priority();
    test_wide();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
